muldiv_seq: RTL

Multi-cycle controller that runs MULTU/DIVU by driving the core's shared 32-bit ripple ALU one step per cycle.
- Multiply: shift-add. Divide: restoring.
- Sits beside the ALU in the execute stage. While `alu_own` is high, the execute-stage mux hands ALU operands and control to this block.
- Result is delivered as a HI/LO pair to the HI/LO registers, with a start/busy/done handshake toward the control unit.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_step.sv | 65 ++++++
 rtl/muldiv_seq.sv | 133 +++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared constants for the sequential MULTU/DIVU unit
// Purpose: ALU control codes, operation encodings, FSM state encodings and
//          the default operand width used by muldiv_seq and muldiv_step.
// Ports:   none (package).
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  // ALU control; bit 2 doubles as the ALU carry-in.
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;

  localparam logic OP_MULTU = 1'b0;
  localparam logic OP_DIVU  = 1'b1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one shift-add / restoring-divide iteration
// Purpose: purely combinational step logic. Drives the shared ALU operands
//          and builds the next HI/LO from the ALU result.
// Ports:
//   op        in   0 = MULTU, 1 = DIVU
//   hi, lo    in   current HI/LO registers
//   opnd      in   multiplicand (MULTU) or divisor (DIVU)
//   alu_r     in   ALU result
//   alu_cout  in   ALU carry out of the top bit
//   alu_a/b   out  ALU operands
//   alu_ctr   out  ALU control
//   hi_next   out  HI after this step
//   lo_next   out  LO after this step
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            op,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opnd,
  input  logic [XLEN-1:0] alu_r,
  input  logic            alu_cout,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_ctr,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN-1:0] sh;
  logic            acc;

  always_comb begin
    // Divide: partial remainder shifted left, pulling in the next dividend bit.
    sh = {hi[XLEN-2:0], lo[XLEN-1]};
    // The bit shifted out of HI makes the 33-bit remainder exceed any divisor,
    // so the subtraction is taken even when the ALU reports a borrow.
    acc = hi[XLEN-1] | alu_cout;

    alu_a   = '0;
    alu_b   = '0;
    alu_ctr = ALU_ADD;
    hi_next = hi;
    lo_next = lo;

    if (op == OP_DIVU) begin
      alu_a   = sh;
      alu_b   = opnd;
      alu_ctr = ALU_SUB;
      hi_next = acc ? alu_r : sh;
      lo_next = {lo[XLEN-2:0], acc};
    end else begin
      // Multiply: add the multiplicand when the current multiplier bit is set,
      // then shift the 65-bit {cout, HI, LO} right by one.
      alu_a   = hi;
      alu_b   = lo[0] ? opnd : '0;
      alu_ctr = ALU_ADD;
      hi_next = {alu_cout, alu_r[XLEN-1:1]};
      lo_next = {alu_r[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle MULTU/DIVU controller on the shared ALU
// Purpose: IDLE -> RUN (STEPS cycles) -> DONE sequencer. Borrows the execute
//          stage ALU while alu_own is high and delivers a HI/LO result.
// Ports:
//   clk, reset     in   clock (rising edge), async active-high reset
//   start          in   request, sampled only in IDLE
//   op             in   0 = MULTU, 1 = DIVU, sampled with start
//   src_a, src_b   in   multiplicand/dividend, multiplier/divisor
//   alu_r          in   ALU result
//   alu_cout       in   ALU carry out
//   alu_a, alu_b   out  ALU operands (zero outside RUN)
//   alu_ctr        out  ALU control (ADD outside RUN)
//   alu_own        out  block owns the ALU
//   busy           out  operation in progress
//   done           out  one-cycle pulse, HI/LO valid
//   hi, lo         out  product high/low or remainder/quotient
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int STEPS = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [XLEN-1:0] alu_r,
  input  logic            alu_cout,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_ctr,
  output logic            alu_own,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  logic [1:0]      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic            op_q, op_d;
  logic [XLEN-1:0] opnd_q, opnd_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;

  logic [XLEN-1:0] step_a, step_b, step_hi, step_lo;
  logic [2:0]      step_ctr;
  logic            run;

  assign run = (state_q == RUN);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .op       (op_q),
    .hi       (hi_q),
    .lo       (lo_q),
    .opnd     (opnd_q),
    .alu_r    (alu_r),
    .alu_cout (alu_cout),
    .alu_a    (step_a),
    .alu_b    (step_b),
    .alu_ctr  (step_ctr),
    .hi_next  (step_hi),
    .lo_next  (step_lo)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          opnd_d  = src_b;
          hi_d    = '0;
          lo_d    = src_a;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        hi_d    = step_hi;
        lo_d    = step_lo;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(STEPS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      op_q    <= OP_MULTU;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy    = run;
  assign alu_own = run;
  assign done    = (state_q == DONE);
  // The execute-stage mux only listens while alu_own is high; parking the
  // operands at zero/ADD keeps the ALU quiet the rest of the time.
  assign alu_a   = run ? step_a   : '0;
  assign alu_b   = run ? step_b   : '0;
  assign alu_ctr = run ? step_ctr : ALU_ADD;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule
